// File: rtl/dlsc_pxdma_arbiter.sv
// dlsc_pxdma_arbiter: shares one AXI row-command engine between PORTS pxdma
// command sources. Round-robin grant into a single output register stage,
// in-order tag FIFO recording the owning port of each in-flight command, and
// per-port routing of engine completion pulses.
// Optional build macro DLSC_PXDMA_ARB_PRIO0_EN: port 0 gets absolute priority,
// ports 1..PORTS-1 round-robin among themselves.
module dlsc_pxdma_arbiter #(
  parameter int unsigned PORTS    = 2,
  parameter int unsigned AXI_ADDR = 32,
  parameter int unsigned BLEN     = 12,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PORTS-1:0]         in_cmd_ready,
  input  logic [PORTS-1:0]         in_cmd_valid,
  input  logic [PORTS*AXI_ADDR-1:0] in_cmd_addr,
  input  logic [PORTS*BLEN-1:0]    in_cmd_bytes,
  output logic [PORTS-1:0]         in_cmd_done,
  input  logic                     out_cmd_ready,
  output logic                     out_cmd_valid,
  output logic [AXI_ADDR-1:0]      out_cmd_addr,
  output logic [BLEN-1:0]          out_cmd_bytes,
  input  logic                     out_cmd_done,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(PORTS);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [AXI_ADDR-1:0] out_addr_q, out_addr_d;
  logic [BLEN-1:0]     out_bytes_q, out_bytes_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PORTS-1:0]    done_q, done_d;
  logic                busy_q, busy_d;
  logic                dlsc_error_q, dlsc_error_d;
  logic [IDX_W-1:0]    tag_q [DEPTH];

  logic [IDX_W-1:0]    winner_c;
  logic [IDX_W-1:0]    idx_c;
  logic                found_c;
  logic                slot_free_c;
  logic                grant_c;
  logic                pop_c;

  // Pick the first requesting port after the round-robin pointer
  always_comb begin
    winner_c = '0;
    idx_c    = '0;
    found_c  = 1'b0;
`ifdef DLSC_PXDMA_ARB_PRIO0_EN
    if (in_cmd_valid[0]) begin
      found_c = 1'b1;
    end else begin
      for (int unsigned i = 1; i < PORTS; i++) begin
        idx_c = IDX_W'(((32'(ptr_q) + PORTS - 2 + i) % (PORTS - 1)) + 1);
        if (!found_c && in_cmd_valid[idx_c]) begin
          found_c  = 1'b1;
          winner_c = idx_c;
        end
      end
    end
`else
    for (int unsigned i = 1; i <= PORTS; i++) begin
      idx_c = IDX_W'((32'(ptr_q) + i) % PORTS);
      if (!found_c && in_cmd_valid[idx_c]) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
`endif
  end

  assign slot_free_c = !out_valid_q || out_cmd_ready;
  assign grant_c     = slot_free_c && (count_q < CNT_W'(DEPTH)) && found_c;
  assign pop_c       = out_cmd_done && (count_q != '0);

  // One-hot accept strobe for the granted port only
  always_comb begin
    in_cmd_ready = '0;
    if (grant_c) in_cmd_ready[winner_c] = 1'b1;
  end

  // Next-state: pointer, output slot, tag FIFO bookkeeping, completion routing
  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_bytes_d  = out_bytes_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    done_d       = '0;
    dlsc_error_d = dlsc_error_q;

    if (grant_c) begin
`ifdef DLSC_PXDMA_ARB_PRIO0_EN
      if (winner_c != '0) ptr_d = winner_c;
`else
      ptr_d = winner_c;
`endif
    end

    if (slot_free_c) begin
      out_valid_d = grant_c;
      if (grant_c) begin
        out_addr_d  = in_cmd_addr[32'(winner_c)*AXI_ADDR +: AXI_ADDR];
        out_bytes_d = in_cmd_bytes[32'(winner_c)*BLEN +: BLEN];
      end
    end

    if (grant_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) begin
      rd_ptr_d               = rd_ptr_q + PTR_W'(1);
      done_d[tag_q[rd_ptr_q]] = 1'b1;
    end
    count_d = count_q + CNT_W'(grant_c) - CNT_W'(pop_c);

    // Completion with nothing in flight is a protocol error on the engine side
    if (out_cmd_done && (count_q == '0)) dlsc_error_d = 1'b1;

    busy_d = out_valid_d || (count_d != '0);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= IDX_W'(PORTS - 1);
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_bytes_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      dlsc_error_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_bytes_q  <= out_bytes_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      dlsc_error_q <= dlsc_error_d;
    end
  end

  // Tag FIFO storage: owning port of each in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else if (grant_c) begin
      tag_q[wr_ptr_q] <= winner_c;
    end
  end

  assign out_cmd_valid = out_valid_q;
  assign out_cmd_addr  = out_addr_q;
  assign out_cmd_bytes = out_bytes_q;
  assign in_cmd_done   = done_q;
  assign busy          = busy_q;

endmodule
